// File: rtl/mul_uint_seq.sv
// mul_uint_seq: iterative radix-2 shift-add unsigned multiplier with valid/ready handshakes
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   A, B                WIDTH-bit multiplicand / multiplier, latched on accept
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   P                   product, WIDTH bits (FULL_PRODUCT=0) or 2*WIDTH bits
//   ovf                 truncated product lost high bits (always 0 when FULL_PRODUCT=1)
module mul_uint_seq #(
    parameter int WIDTH        = 8,
    parameter int FULL_PRODUCT = 0,
    parameter int EARLY_EXIT   = 0,
    localparam int OUT_W       = (FULL_PRODUCT != 0) ? 2 * WIDTH : WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] P,
    output logic             ovf
);
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc, mcand, acc_add;
    logic [WIDTH-1:0]     mplier, b_shift;
    logic [KW-1:0]        k;
    logic                 last;

    // mcand holds A<<k, so the add at bit k is a plain addition.
    assign acc_add = mplier[0] ? acc + mcand : acc;
    assign b_shift = mplier >> 1;
    assign last    = (k == KW'(WIDTH - 1)) || ((EARLY_EXIT != 0) && (b_shift == '0));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = in_valid ? BUSY : IDLE;
            BUSY:    state_nxt = last ? DONE : BUSY;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            k      <= '0;
            P      <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                k      <= '0;
            end
            if (state == BUSY) begin
                acc    <= acc_add;
                mcand  <= mcand << 1;
                mplier <= b_shift;
                k      <= k + KW'(1);
                // Result is captured once on the final BUSY edge and held through DONE.
                if (last) begin
                    P   <= acc_add[OUT_W-1:0];
                    ovf <= (FULL_PRODUCT == 0) && (|acc_add[2*WIDTH-1:WIDTH]);
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_uint_seq.sv
// tb_mul_uint_seq: self-checking bench over five multiplier configurations
module tb_mul_uint_seq;
    localparam int CW[5]  = '{8, 8, 8, 16, 16};
    localparam int CFP[5] = '{0, 1, 0, 0, 1};
    localparam int CEE[5] = '{0, 0, 1, 0, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  iv, ir, ov, orr, ovf;
    logic [15:0] av[5], bv[5];
    logic [31:0] pv[5];
    logic [7:0]  p0, p2;
    logic [15:0] p1, p3;
    logic [31:0] p4;
    logic [32:0] sb[5][$];
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        int          inst;
        logic [15:0] a, b;
        logic [31:0] p;
        logic        o;
        int          lat;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    mul_uint_seq #(.WIDTH(8), .FULL_PRODUCT(0), .EARLY_EXIT(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(av[0][7:0]), .B(bv[0][7:0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .P(p0), .ovf(ovf[0]));
    mul_uint_seq #(.WIDTH(8), .FULL_PRODUCT(1), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(av[1][7:0]), .B(bv[1][7:0]),
        .out_valid(ov[1]), .out_ready(orr[1]), .P(p1), .ovf(ovf[1]));
    mul_uint_seq #(.WIDTH(8), .FULL_PRODUCT(0), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(av[2][7:0]), .B(bv[2][7:0]),
        .out_valid(ov[2]), .out_ready(orr[2]), .P(p2), .ovf(ovf[2]));
    mul_uint_seq #(.WIDTH(16), .FULL_PRODUCT(0), .EARLY_EXIT(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .A(av[3]), .B(bv[3]),
        .out_valid(ov[3]), .out_ready(orr[3]), .P(p3), .ovf(ovf[3]));
    mul_uint_seq #(.WIDTH(16), .FULL_PRODUCT(1), .EARLY_EXIT(0)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .A(av[4]), .B(bv[4]),
        .out_valid(ov[4]), .out_ready(orr[4]), .P(p4), .ovf(ovf[4]));

    assign pv[0] = {24'b0, p0};
    assign pv[1] = {16'b0, p1};
    assign pv[2] = {24'b0, p2};
    assign pv[3] = {16'b0, p3};
    assign pv[4] = p4;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // One transaction on instance i, starting and ending at a negedge.
    task automatic op(input int i, input logic [15:0] a_in, input logic [15:0] b_in, input int hold,
                      input bit poke, output logic [31:0] gp, output logic go, output int lat);
        int          w, guard, m, exp_lat;
        logic [31:0] full, mask;
        logic [15:0] a, b;
        logic [32:0] e;
        w    = CW[i];
        mask = (w == 16) ? 32'hFFFF : 32'hFF;
        a    = a_in & mask[15:0];
        b    = b_in & mask[15:0];
        full = {16'b0, a} * {16'b0, b};
        m    = 0;
        for (int k = 0; k < w; k++) if (b[k]) m = k + 1;
        exp_lat = (CEE[i] != 0) ? ((m == 0) ? 1 : m) + 1 : w + 1;
        av[i] = a;
        bv[i] = b;
        iv[i] = 1'b1;
        guard = 0;
        while (!ir[i] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ir[i]) chk("in_ready_timeout", 32'(ir[i]), 32'd1);
        @(posedge clk);
        sb[i].push_back({(CFP[i] != 0) ? 1'b0 : |(full & ~mask), (CFP[i] != 0) ? full : (full & mask)});
        lat = 1;
        @(negedge clk);
        iv[i] = 1'b0;
        av[i] = ~a;
        bv[i] = ~b;
        guard = 0;
        while (!ov[i] && guard < 40) begin
            @(negedge clk);
            lat++;
            guard++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (sb[i].size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            e = '0;
        end else e = sb[i].pop_front();
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(ov[i]), 32'd1);
            chk("hold_p", pv[i], e[31:0]);
            chk("hold_in_ready", 32'(ir[i]), 32'd0);
            if (poke) begin
                iv[i] = 1'b1;
                av[i] = a + 16'd1;
                bv[i] = b + 16'd1;
            end
            @(negedge clk);
        end
        iv[i] = 1'b0;
        chk("p", pv[i], e[31:0]);
        chk("ovf", 32'(ovf[i]), 32'(e[32]));
        gp = pv[i];
        go = ovf[i];
        orr[i] = 1'b1;
        @(negedge clk);
        orr[i] = 1'b0;
        chk("post_valid", 32'(ov[i]), 32'd0);
        chk("post_in_ready", 32'(ir[i]), 32'd1);
    endtask

    task automatic run_rand(input int i);
        logic [31:0] gp;
        logic        go;
        int          lat;
        for (int n = 0; n < 1000; n++) begin
            op(i, 16'($urandom), 16'($urandom), $urandom_range(2), 1'b0, gp, go, lat);
            repeat ($urandom_range(1)) @(negedge clk);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gp;
        logic        go;
        int          lat;
        bit          seen;
        tbl[0]  = '{0, 16'd13,    16'd11,    32'd143,        1'b0, 9};
        tbl[1]  = '{0, 16'd255,   16'd255,   32'h01,         1'b1, 9};
        tbl[2]  = '{1, 16'd255,   16'd255,   32'hFE01,       1'b0, 9};
        tbl[3]  = '{2, 16'd200,   16'd0,     32'd0,          1'b0, 2};
        tbl[4]  = '{2, 16'd5,     16'd3,     32'd15,         1'b0, 3};
        tbl[5]  = '{2, 16'd3,     16'h80,    32'd128,        1'b1, 9};
        tbl[6]  = '{3, 16'hFFFF,  16'hFFFF,  32'h0001,       1'b1, 17};
        tbl[7]  = '{4, 16'hFFFF,  16'hFFFF,  32'hFFFE0001,   1'b0, 17};
        tbl[8]  = '{0, 16'd16,    16'd16,    32'd0,          1'b1, 9};
        tbl[9]  = '{0, 16'd15,    16'd17,    32'd255,        1'b0, 9};
        tbl[10] = '{2, 16'd1,     16'd1,     32'd1,          1'b0, 2};
        tbl[11] = '{4, 16'd1234,  16'd5678,  32'h006AE9BC,   1'b0, 17};
        rst = 1'b1;
        iv  = '0;
        orr = '0;
        for (int i = 0; i < 5; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_in_ready", 32'(ir[i]), 32'd1);
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_p", pv[i], 32'd0);
            chk("rst_ovf", 32'(ovf[i]), 32'd0);
        end
        for (int t = 0; t < 12; t++) begin
            op(tbl[t].inst, tbl[t].a, tbl[t].b, 0, 1'b0, gp, go, lat);
            chk("tbl_p", gp, tbl[t].p);
            chk("tbl_ovf", 32'(go), 32'(tbl[t].o));
            chk("tbl_lat", 32'(lat), 32'(tbl[t].lat));
        end
        // Backpressure for 5 cycles with a competing in_valid.
        op(0, 16'd100, 16'd3, 5, 1'b1, gp, go, lat);
        chk("bp_p", gp, 32'd44);
        chk("bp_ovf", 32'(go), 32'd1);
        // Reset sampled on the 4th edge counting the accept edge.
        av[0] = 16'd9;
        bv[0] = 16'd9;
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("busy_rst_in_ready", 32'(ir[0]), 32'd1);
        chk("busy_rst_out_valid", 32'(ov[0]), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        chk("busy_rst_no_result", 32'(seen), 32'd0);
        op(0, 16'd7, 16'd6, 0, 1'b0, gp, go, lat);
        chk("after_rst_p", gp, 32'd42);
        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
            run_rand(3);
            run_rand(4);
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
